filtro_iir_mac: RTL and testbench

// - Sequential second-order IIR (biquad) engine, single shared multiplier.
// - Computes y[k] = b0*x[k] + b1*x[k-1] + b2*x[k-2] - a1*y[k-1] - a2*y[k-2]
//   in signed fixed point, one product per cycle.
// - Sits directly upstream of the Yk output register: Result/Finish drive its In/Finish.

---
 rtl/filtro_iir_mac_pkg.sv | 20 ++
 rtl/redondeo_saturacion.sv | 34 +++
 rtl/filtro_iir_mac.sv | 133 +++++++++++++
 tb/tb_filtro_iir_mac.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_iir_mac_pkg.sv
// Shared definitions for the biquad MAC engine: state encoding, default widths
// and the accumulator width rule.
package filtro_iir_mac_pkg;

   localparam int N_DEF = 25;
   localparam int D_DEF = 16;

   // Five 2N-bit products summed: three guard bits keep the sum from wrapping.
   function automatic int acc_width(input int n);
      return 2 * n + 3;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/redondeo_saturacion.sv
// Combinational post-processing of the accumulator: round half toward +inf,
// drop the D fractional bits, then clip to the signed N-bit range.
module redondeo_saturacion
   import filtro_iir_mac_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int D = D_DEF
) (
   input  logic signed [acc_width(N)-1:0] acc_i,
   output logic signed [N-1:0]            result_o,
   output logic                           sat_o
);

   localparam int AW = acc_width(N);
   localparam logic signed [AW-1:0] HALF = AW'(64'd1 << (D - 1));
   localparam logic signed [AW-1:0] MAXV = AW'((64'd1 << (N - 1)) - 64'd1);
   localparam logic signed [AW-1:0] MINV = ~MAXV;

   logic signed [AW-1:0] rounded;

   always_comb begin
      rounded  = (acc_i + HALF) >>> D;
      result_o = rounded[N-1:0];
      sat_o    = 1'b0;
      if (rounded > MAXV) begin
         result_o = MAXV[N-1:0];
         sat_o    = 1'b1;
      end else if (rounded < MINV) begin
         result_o = MINV[N-1:0];
         sat_o    = 1'b1;
      end
   end

endmodule

// File: rtl/filtro_iir_mac.sv
// Second-order IIR (biquad) engine: one shared multiplier, five MAC cycles per
// sample, then round/saturate, history shift and a one-cycle Finish pulse.
module filtro_iir_mac
   import filtro_iir_mac_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int D = D_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                Start,
   input  logic signed [N-1:0] Xin,
   input  logic signed [N-1:0] B0,
   input  logic signed [N-1:0] B1,
   input  logic signed [N-1:0] B2,
   input  logic signed [N-1:0] A1,
   input  logic signed [N-1:0] A2,
   output logic signed [N-1:0] Result,
   output logic                Finish,
   output logic                Busy,
   output logic                Sat
);

   localparam int AW = acc_width(N);

   state_e               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [N-1:0]  x0_q, x1_q, x2_q, y1_q, y2_q;
   logic signed [N-1:0]  x0_d, x1_d, x2_d, y1_d, y2_d;
   logic signed [N-1:0]  result_q, result_d;
   logic                 sat_q, sat_d;

   logic signed [N-1:0]   coefSel, dataSel;
   logic signed [2*N-1:0] product;
   logic signed [AW-1:0]  productExt;
   logic signed [N-1:0]   satResult;
   logic                  satFlag;

   always_comb begin
      coefSel = B0;
      dataSel = x0_q;
      case (idx_q)
         3'd1:    begin coefSel = B1; dataSel = x1_q; end
         3'd2:    begin coefSel = B2; dataSel = x2_q; end
         3'd3:    begin coefSel = A1; dataSel = y1_q; end
         3'd4:    begin coefSel = A2; dataSel = y2_q; end
         default: begin coefSel = B0; dataSel = x0_q; end
      endcase
   end

   assign product    = coefSel * dataSel;
   assign productExt = {{(AW - 2 * N){product[2*N-1]}}, product};

   redondeo_saturacion #(.N(N), .D(D)) uRedSat (
      .acc_i    (acc_q),
      .result_o (satResult),
      .sat_o    (satFlag)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      x0_d     = x0_q;
      x1_d     = x1_q;
      x2_d     = x2_q;
      y1_d     = y1_q;
      y2_d     = y2_q;
      result_d = result_q;
      sat_d    = sat_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               x0_d    = Xin;
               idx_d   = 3'd0;
               acc_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            // Feedback terms (idx 3,4) carry the minus sign of the recursion.
            if (idx_q < 3'd3) acc_d = acc_q + productExt;
            else              acc_d = acc_q - productExt;
            if (idx_q == 3'd4) state_d = SAT;
            else               idx_d   = idx_q + 3'd1;
         end
         SAT: begin
            result_d = satResult;
            sat_d    = satFlag;
            x2_d     = x1_q;
            x1_d     = x0_q;
            y2_d     = y1_q;
            y1_d     = satResult;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         x0_q     <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         y1_q     <= '0;
         y2_q     <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         x0_q     <= x0_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         y1_q     <= y1_d;
         y2_q     <= y2_d;
         result_q <= result_d;
         sat_q    <= sat_d;
      end
   end

   assign Result = result_q;
   assign Sat    = sat_q;
   assign Finish = (state_q == DONE);
   assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_filtro_iir_mac.sv
// Bench for filtro_iir_mac: directed scenarios plus randomized samples, all
// checked against a plain-arithmetic biquad model with its own history.
module tb_filtro_iir_mac;

   localparam int N = 25;
   localparam int D = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                Start = 1'b0;
   logic signed [N-1:0] Xin = '0;
   logic signed [N-1:0] B0 = '0, B1 = '0, B2 = '0, A1 = '0, A2 = '0;
   logic signed [N-1:0] Result;
   logic                Finish, Busy, Sat;

   int compared   = 0;
   int mismatched = 0;

   // Reference history (x[k-1], x[k-2], y[k-1], y[k-2]) as plain integers.
   longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

   always #5 clk = ~clk;

   filtro_iir_mac #(.N(N), .D(D)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .Start  (Start),
      .Xin    (Xin),
      .B0     (B0),
      .B1     (B1),
      .B2     (B2),
      .A1     (A1),
      .A2     (A2),
      .Result (Result),
      .Finish (Finish),
      .Busy   (Busy),
      .Sat    (Sat)
   );

   function automatic longint sx(input logic [N-1:0] v);
      return longint'($signed(v));
   endfunction

   // Biquad difference equation with round-half-up and clipping to N bits.
   task automatic model_step(input longint xin, output longint y, output logic s);
      longint acc, r, hi, lo;
      hi  = (64'sd1 <<< (N - 1)) - 1;
      lo  = -(64'sd1 <<< (N - 1));
      acc = sx(B0) * xin + sx(B1) * mx1 + sx(B2) * mx2 - sx(A1) * my1 - sx(A2) * my2;
      r   = (acc + (64'sd1 <<< (D - 1))) >>> D;
      s   = 1'b0;
      y   = r;
      if (r > hi) begin y = hi; s = 1'b1; end
      if (r < lo) begin y = lo; s = 1'b1; end
      mx2 = mx1;
      mx1 = xin;
      my2 = my1;
      my1 = y;
   endtask

   task automatic set_coefs(input longint b0, b1, b2, a1, a2);
      B0 = b0[N-1:0];
      B1 = b1[N-1:0];
      B2 = b2[N-1:0];
      A1 = a1[N-1:0];
      A2 = a2[N-1:0];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      Start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
   endtask

   // One sample: Start in cycle 0, then cycles 1..12 are watched; Start is
   // re-pulsed in cycles g1/g2 (with junk Xin) to probe that it is ignored.
   task automatic run_sample(input longint xin, input int g1, input int g2, input string name);
      longint expY;
      logic   expS;
      logic   expBusy, expFin;
      model_step(xin, expY, expS);
      @(negedge clk);
      Start = 1'b1;
      Xin   = xin[N-1:0];
      @(negedge clk);
      Start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         expBusy = (c <= 7);
         expFin  = (c == 7);
         compared++;
         if (Busy !== expBusy) begin
            mismatched++;
            $display("[TB] FAIL %s busy c%0d: got %b want %b", name, c, Busy, expBusy);
         end
         compared++;
         if (Finish !== expFin) begin
            mismatched++;
            $display("[TB] FAIL %s finish c%0d: got %b want %b", name, c, Finish, expFin);
         end
         if (c == 7 || c == 12) begin
            compared++;
            if (sx(Result) != expY || Sat !== expS) begin
               mismatched++;
               $display("[TB] FAIL %s result c%0d: got %0d sat %b want %0d sat %b",
                        name, c, sx(Result), Sat, expY, expS);
            end
         end
         Start = (c == g1 || c == g2);
         if (Start) Xin = N'($urandom);
         @(negedge clk);
      end
      Start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      compared++;
      if (Result !== '0 || Finish !== 1'b0 || Busy !== 1'b0 || Sat !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset: got R=%0d F=%b B=%b S=%b want 0/0/0/0",
                  sx(Result), Finish, Busy, Sat);
      end
      do_reset();
   endtask

   task automatic test_impulse();
      do_reset();
      set_coefs(65536, 0, 0, 0, 0);
      run_sample(16384, 0, 0, "impulse");
   endtask

   task automatic test_recursion();
      do_reset();
      set_coefs(65536, 0, 0, -32768, 0);
      run_sample(65536, 0, 0, "recur0");
      run_sample(0, 0, 0, "recur1");
      run_sample(0, 0, 0, "recur2");
   endtask

   task automatic test_saturation();
      do_reset();
      set_coefs(65536, 65536, 65536, 0, 0);
      for (int i = 0; i < 3; i++) run_sample(16777215, 0, 0, "sat_pos");
      for (int i = 0; i < 3; i++) run_sample(-16777216, 0, 0, "sat_neg");
   endtask

   task automatic test_rounding();
      do_reset();
      set_coefs(32768, 0, 0, 0, 0);
      run_sample(3, 0, 0, "round_pos");
      run_sample(-3, 0, 0, "round_neg");
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_coefs(40000, 30000, -20000, 10000, -5000);
      run_sample(100000, 0, 0, "b2b_pre");
      run_sample(-70000, 3, 7, "b2b_glitch");
      run_sample(50000, 0, 0, "b2b_post");
   endtask

   task automatic test_reset_midrun();
      do_reset();
      set_coefs(65536, 0, 0, 0, 0);
      run_sample(1000, 0, 0, "pre_abort");
      @(negedge clk);
      Start = 1'b1;
      Xin   = N'(12345);
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if (Result !== '0 || Busy !== 1'b0 || Finish !== 1'b0 || Sat !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort: got R=%0d B=%b F=%b S=%b want 0/0/0/0",
                  sx(Result), Busy, Finish, Sat);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         compared++;
         if (Finish !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_nofinish c%0d: got %b want 0", c, Finish);
         end
      end
      run_sample(16384, 0, 0, "post_abort_impulse");
      set_coefs(20000, 45000, -33000, 12000, 7000);
      run_sample(-2000000, 0, 0, "post_abort_hist");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         if (i % 6 == 0) begin
            set_coefs(sx(N'($urandom)) >>> 6, sx(N'($urandom)) >>> 6, sx(N'($urandom)) >>> 6,
                      sx(N'($urandom)) >>> 7, sx(N'($urandom)) >>> 8);
         end
         run_sample(sx(N'($urandom)), 0, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_recursion();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
